// File: rtl/dpram_stream_reader_pkg.sv
// Shared types and helpers for the dual-port RAM stream reader.
package dpram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_t;

    // Pointer width needed to index a FIFO of the given (power-of-two) depth.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dpram_stream_reader_if.sv
// RAM read port plus outgoing valid/ready stream, bundled for the reader.
interface dpram_stream_reader_if #(
    parameter int data_width_g = 8,
    parameter int addr_width_g = 14
);
    logic                    mem_cs;
    logic                    mem_wren;
    logic [addr_width_g-1:0] mem_address;
    logic [data_width_g-1:0] mem_q;
    logic                    out_valid;
    logic [data_width_g-1:0] out_data;
    logic                    out_ready;

    // Reader side: drives the RAM request and the stream payload.
    modport master (
        output mem_cs, mem_wren, mem_address, out_valid, out_data,
        input  mem_q, out_ready
    );

    // RAM and consumer side.
    modport slave (
        input  mem_cs, mem_wren, mem_address, out_valid, out_data,
        output mem_q, out_ready
    );
endinterface

// File: rtl/dpram_stream_reader_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; dout shows the head word.
module sync_fifo
    import dpram_rd_pkg::*;
#(
    parameter int data_width_g = 8,
    parameter int fifo_depth_g = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic                                  pop,
    input  logic                                  flush,
    input  logic [data_width_g-1:0]               din,
    output logic [data_width_g-1:0]               dout,
    output logic                                  empty,
    output logic [fifo_ptr_width(fifo_depth_g):0] count
);
    localparam int               ptr_w_c   = fifo_ptr_width(fifo_depth_g);
    localparam logic [ptr_w_c:0] depth_c   = (ptr_w_c + 1)'(fifo_depth_g);
    localparam logic [ptr_w_c:0] cnt_one_c = (ptr_w_c + 1)'(1);
    localparam logic [ptr_w_c-1:0] ptr_one_c = ptr_w_c'(1);

    logic [data_width_g-1:0] ram_q [fifo_depth_g];
    logic [ptr_w_c-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w_c-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ptr_w_c:0]        count_q, count_d;
    logic                    do_push_s, do_pop_s;

    // Pointer and occupancy update; flush dominates push and pop.
    always_comb begin
        do_push_s = push && (count_q != depth_c) && !flush;
        do_pop_s  = pop && (count_q != '0) && !flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + ptr_one_c;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + ptr_one_c;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + cnt_one_c;
            end else if (!do_push_s && do_pop_s) begin
                count_d = count_q - cnt_one_c;
            end else begin
                count_d = count_q;
            end
        end
    end

    // Control registers; storage contents need no reset since count gates them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage write port.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            ram_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = ram_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Sequential RAM reader: issues credit-limited single-word reads and streams
// the returned words out through a small FIFO.
module dpram_stream_reader
    import dpram_rd_pkg::*;
#(
    parameter int data_width_g = 8,
    parameter int addr_width_g = 14,
    parameter int fifo_depth_g = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic [addr_width_g-1:0] cmd_base,
    input  logic [addr_width_g:0]   cmd_len,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    dpram_stream_reader_if.master   bus
);
    localparam int                    ptr_w_c    = fifo_ptr_width(fifo_depth_g);
    localparam logic [ptr_w_c+1:0]    depth_c    = (ptr_w_c + 2)'(fifo_depth_g);
    localparam logic [addr_width_g-1:0] addr_one_c = addr_width_g'(1);
    localparam logic [addr_width_g:0] cnt_one_c  = (addr_width_g + 1)'(1);

    rd_state_t               state_q, state_d;
    logic [addr_width_g-1:0] addr_q, addr_d;
    logic [addr_width_g:0]   len_q, len_d;
    logic [addr_width_g:0]   issued_q, issued_d;
    logic [addr_width_g:0]   out_cnt_q, out_cnt_d;
    logic                    pend_q, pend_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    cs_s, push_s, pop_s, flush_s, empty_s;
    logic [data_width_g-1:0] fifo_dout_s;
    logic [ptr_w_c:0]        fifo_count_s;
    logic [ptr_w_c+1:0]      credit_s;

    sync_fifo #(
        .data_width_g (data_width_g),
        .fifo_depth_g (fifo_depth_g)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (bus.mem_q),
        .dout  (fifo_dout_s),
        .empty (empty_s),
        .count (fifo_count_s)
    );

    // Read issue: a slot must be free counting the word still in flight from the RAM.
    always_comb begin
        credit_s = {1'b0, fifo_count_s} + {{(ptr_w_c + 1){1'b0}}, pend_q};
        cs_s     = (state_q == RUN) && (issued_q < len_q) && (credit_s < depth_c) && !abort;
        pop_s    = !empty_s && bus.out_ready;
    end

    // Next-state, counters and FIFO control.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        out_cnt_d = out_cnt_q;
        pend_d    = 1'b0;
        flush_s   = 1'b0;
        push_s    = pend_q;
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    if (cmd_len != '0) begin
                        addr_d    = cmd_base;
                        len_d     = cmd_len;
                        issued_d  = '0;
                        out_cnt_d = '0;
                        state_d   = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    // The word returning this cycle is dropped along with the FIFO.
                    state_d = IDLE;
                    flush_s = 1'b1;
                    push_s  = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    if (cs_s) begin
                        addr_d   = addr_q + addr_one_c;
                        issued_d = issued_q + cnt_one_c;
                        pend_d   = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                    end
                    if (pop_s) begin
                        out_cnt_d = out_cnt_q + cnt_one_c;
                        if ((out_cnt_q + cnt_one_c) == len_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        out_cnt_d = out_cnt_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // FSM state, counters and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            out_cnt_q <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            out_cnt_q <= out_cnt_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.mem_cs      = cs_s;
    assign bus.mem_wren    = 1'b0;
    assign bus.mem_address = addr_q;
    assign bus.out_valid   = !empty_s;
    assign bus.out_data    = fifo_dout_s;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomized bench for dpram_stream_reader: a behavioural RAM plus a
// reference stream computed as ram[(base + k) mod 2**14].
module tb_dpram_stream_reader;
    localparam int dw        = 8;
    localparam int aw        = 14;
    localparam int depth     = 4;
    localparam int ram_words = 1 << aw;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic [aw-1:0] cmd_base;
    logic [aw:0]   cmd_len;
    logic          abort;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    logic [dw-1:0] ram [ram_words];

    logic [dw-1:0] got_q [$];
    int done_cnt, cs_cnt, max_out, stable_viol, timed_out;
    logic busy_after;

    dpram_stream_reader_if #(.data_width_g(dw), .addr_width_g(aw)) bus();

    dpram_stream_reader #(
        .data_width_g (dw),
        .addr_width_g (aw),
        .fifo_depth_g (depth)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .cmd_start (cmd_start),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, one cycle after chip select.
    always @(posedge clk) begin
        if (bus.mem_cs === 1'b1) bus.mem_q <= ram[bus.mem_address];
    end

    function automatic logic [dw-1:0] ref_word(input logic [aw-1:0] base, input int k);
        return ram[aw'(int'(base) + k)];
    endfunction

    // Issue one command and observe it until done, recording stream and handshake stats.
    task automatic run_cmd(input logic [aw-1:0] base, input logic [aw:0] len, input int ready_pct);
        int issued, accepted, c;
        logic prev_stall;
        logic [dw-1:0] prev_data;
        bit fin;
        got_q.delete();
        done_cnt = 0; cs_cnt = 0; max_out = 0; stable_viol = 0; timed_out = 0;
        issued = 0; accepted = 0; c = 0; fin = 0; prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        cmd_base = base; cmd_len = len; cmd_start = 1'b1;
        bus.out_ready = ($urandom_range(99) < ready_pct);
        while (!fin) begin
            @(negedge clk);
            cmd_start = 1'b0;
            c++;
            bus.out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) stable_viol++;
            if (bus.mem_cs === 1'b1) begin issued++; cs_cnt++; end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_q.push_back(bus.out_data);
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = (bus.out_valid === 1'b1 && bus.out_ready !== 1'b1);
            prev_data  = bus.out_data;
            if (done === 1'b1) begin done_cnt++; fin = 1; end
            if (c >= 2000) begin timed_out = 1; fin = 1; end
        end
        @(negedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_start = 1'b0; abort = 1'b0; cmd_base = '0; cmd_len = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", bus.mem_cs); end
        checks++; if (bus.mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", bus.mem_wren); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.mem_address !== 14'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.mem_address); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_cs, exp_valid, exp_done, exp_busy;
        logic [dw-1:0] exp_data;
        logic [aw-1:0] exp_addr;
        for (int i = 0; i < ram_words; i++) ram[i] = i[7:0];
        bus.out_ready = 1'b1;
        @(negedge clk);
        cmd_base = 14'h0010; cmd_len = 15'd4; cmd_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            #1;
            exp_cs    = (c <= 4);
            exp_valid = (c >= 3 && c <= 6);
            exp_done  = (c == 7);
            exp_busy  = (c <= 6);
            checks++; if (bus.mem_cs !== exp_cs) begin errors++; $display("FAIL basic_cs cycle %0d got %b want %b", c, bus.mem_cs, exp_cs); end
            checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL basic_valid cycle %0d got %b want %b", c, bus.out_valid, exp_valid); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL basic_done cycle %0d got %b want %b", c, done, exp_done); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL basic_busy cycle %0d got %b want %b", c, busy, exp_busy); end
            if (exp_cs) begin
                exp_addr = 14'h0010 + 14'(c - 1);
                checks++; if (bus.mem_address !== exp_addr) begin errors++; $display("FAIL basic_addr cycle %0d got %h want %h", c, bus.mem_address, exp_addr); end
            end
            if (exp_valid) begin
                exp_data = 8'h10 + 8'(c - 3);
                checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL basic_data cycle %0d got %h want %h", c, bus.out_data, exp_data); end
            end
        end
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < ram_words; i++) ram[i] = 8'($urandom);
    endtask

    task automatic test_backpressure();
        logic [aw-1:0] base;
        logic [dw-1:0] got [$];
        int cs_n, c;
        bit seen_done;
        base = 14'($urandom);
        bus.out_ready = 1'b1;
        @(negedge clk);
        cmd_base = base; cmd_len = 15'd8; cmd_start = 1'b1;
        cs_n = 0; c = 0; seen_done = 0;
        while (!seen_done && c < 200) begin
            @(negedge clk);
            cmd_start = 1'b0;
            c++;
            bus.out_ready = (c < 2 || c > 20);
            #1;
            if (bus.mem_cs === 1'b1) cs_n++;
            if (c >= 3 && c <= 20) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== ref_word(base, 0)) begin
                    errors++; $display("FAIL bp_hold cycle %0d got valid %b data %h want valid 1 data %h", c, bus.out_valid, bus.out_data, ref_word(base, 0));
                end
            end
            if (c == 20) begin
                checks++; if (cs_n !== 4) begin errors++; $display("FAIL bp_outstanding got %0d reads want 4", cs_n); end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
            if (done === 1'b1) seen_done = 1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL bp_done got no done pulse within %0d cycles want one", c); end
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_count got %0d words want 8", got.size()); end
        if (got.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++; if (got[k] !== ref_word(base, k)) begin errors++; $display("FAIL bp_word %0d got %h want %h", k, got[k], ref_word(base, k)); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [aw-1:0] exp_a [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        logic [aw-1:0] addrs [$];
        logic [dw-1:0] got [$];
        int c;
        bit seen_done;
        bus.out_ready = 1'b1;
        @(negedge clk);
        cmd_base = 14'h3FFE; cmd_len = 15'd4; cmd_start = 1'b1;
        c = 0; seen_done = 0;
        while (!seen_done && c < 100) begin
            @(negedge clk);
            cmd_start = 1'b0;
            c++;
            #1;
            if (bus.mem_cs === 1'b1) addrs.push_back(bus.mem_address);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
            if (done === 1'b1) seen_done = 1;
        end
        checks++; if (addrs.size() !== 4 || got.size() !== 4 || !seen_done) begin
            errors++; $display("FAIL wrap_counts got %0d reads %0d words done %0d want 4 4 1", addrs.size(), got.size(), seen_done);
        end
        if (addrs.size() == 4 && got.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (addrs[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr %0d got %h want %h", k, addrs[k], exp_a[k]); end
                checks++; if (got[k] !== ram[exp_a[k]]) begin errors++; $display("FAIL wrap_word %0d got %h want %h", k, got[k], ram[exp_a[k]]); end
            end
        end
    endtask

    task automatic test_zero();
        bus.out_ready = 1'b1;
        @(negedge clk);
        cmd_base = 14'($urandom); cmd_len = 15'd0; cmd_start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            #1;
            checks++; if (done !== (c == 1)) begin errors++; $display("FAIL zero_done cycle %0d got %b want %b", c, done, (c == 1)); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy cycle %0d got %b want 0", c, busy); end
            checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL zero_cs cycle %0d got %b want 0", c, bus.mem_cs); end
        end
    endtask

    task automatic test_abort();
        logic [aw-1:0] base_b;
        // Held-off consumer, abort in cycle 5.
        bus.out_ready = 1'b0;
        @(negedge clk);
        cmd_base = 14'($urandom); cmd_len = 15'd16; cmd_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            abort = (c == 5);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone cycle %0d got %b want 0", c, done); end
            if (c == 4) begin
                checks++; if (bus.mem_cs !== 1'b1) begin errors++; $display("FAIL abort_pre_cs got %b want 1", bus.mem_cs); end
            end
            if (c == 5) begin
                checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL abort_cs got %b want 0", bus.mem_cs); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy5 got %b want 1", busy); end
            end
            if (c == 6) begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.out_valid); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy6 got %b want 0", busy); end
            end
        end
        abort = 1'b0;
        // A fresh command must stream from its own base with nothing stale ahead of it.
        base_b = 14'($urandom);
        run_cmd(base_b, 15'd5, 100);
        checks++; if (timed_out != 0 || got_q.size() != 5) begin errors++; $display("FAIL abort_restart got %0d words timeout %0d want 5 words", got_q.size(), timed_out); end
        if (got_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (got_q[k] !== ref_word(base_b, k)) begin errors++; $display("FAIL abort_word %0d got %h want %h", k, got_q[k], ref_word(base_b, k)); end
            end
        end
        // Streaming consumer, abort in cycle 3 when a read would otherwise issue.
        bus.out_ready = 1'b1;
        @(negedge clk);
        cmd_base = 14'($urandom); cmd_len = 15'd16; cmd_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            abort = (c == 3);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abortb_nodone cycle %0d got %b want 0", c, done); end
            if (c == 3) begin
                checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL abortb_cs got %b want 0", bus.mem_cs); end
            end
            if (c >= 4) begin
                checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.mem_cs !== 1'b0) begin
                    errors++; $display("FAIL abortb_idle cycle %0d got valid %b busy %b cs %b want 0 0 0", c, bus.out_valid, busy, bus.mem_cs);
                end
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [aw-1:0] base;
        bus.out_ready = 1'b1;
        @(negedge clk);
        cmd_base = 14'($urandom); cmd_len = 15'd8; cmd_start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cmd_start = 1'b0;
        end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_status got busy %b done %b want 0 0", busy, done); end
        checks++; if (bus.mem_cs !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_bus got cs %b valid %b want 0 0", bus.mem_cs, bus.out_valid); end
        checks++; if (bus.mem_address !== 14'h0000) begin errors++; $display("FAIL rstmid_addr got %h want 0000", bus.mem_address); end
        @(negedge clk);
        rst = 1'b0;
        base = 14'($urandom);
        run_cmd(base, 15'd6, 100);
        checks++; if (timed_out != 0 || got_q.size() != 6 || done_cnt != 1) begin
            errors++; $display("FAIL rstmid_next got %0d words %0d done timeout %0d want 6 1 0", got_q.size(), done_cnt, timed_out);
        end
        if (got_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (got_q[k] !== ref_word(base, k)) begin errors++; $display("FAIL rstmid_word %0d got %h want %h", k, got_q[k], ref_word(base, k)); end
            end
        end
    endtask

    task automatic test_random();
        logic [aw-1:0] base;
        logic [aw:0]   len;
        int            pct;
        int            bad;
        for (int t = 0; t < 25; t++) begin
            base = ($urandom_range(3) == 0) ? 14'(32'h3FF0 + $urandom_range(15)) : 14'($urandom);
            len  = 15'($urandom_range(40));
            case ($urandom_range(2))
                0: pct = 100;
                1: pct = 50;
                default: pct = 20;
            endcase
            run_cmd(base, len, pct);
            checks++; if (timed_out != 0) begin errors++; $display("FAIL rand_timeout t%0d got timeout want completion", t); end
            checks++; if (got_q.size() != int'(len)) begin errors++; $display("FAIL rand_count t%0d got %0d words want %0d", t, got_q.size(), len); end
            checks++; if (cs_cnt != int'(len)) begin errors++; $display("FAIL rand_reads t%0d got %0d reads want %0d", t, cs_cnt, len); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done t%0d got %0d done pulses want 1", t, done_cnt); end
            checks++; if (max_out > depth) begin errors++; $display("FAIL rand_credit t%0d got %0d outstanding want <= %0d", t, max_out, depth); end
            checks++; if (stable_viol != 0) begin errors++; $display("FAIL rand_stable t%0d got %0d stall violations want 0", t, stable_viol); end
            checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL rand_busy_after t%0d got %b want 0", t, busy_after); end
            bad = 0;
            for (int k = 0; k < got_q.size(); k++) begin
                if (got_q[k] !== ref_word(base, k)) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_data t%0d got %0d wrong words want 0 (base %h len %0d)", t, bad, base, len); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        randomize_ram();
        test_backpressure();
        test_wrap();
        test_zero();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no completion want finish before %0t", $time);
        $fatal(1);
    end

endmodule
